// File: rtl/product_accumulator_if.sv
// Beat/result handshake bundle between the multiplier, the product accumulator and its consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
);
  logic [1:0]       i_Numerical_Precision;
  logic [47:0]      i_product;
  logic             i_valid;
  logic             i_last;
  logic             o_in_ready;
  logic             i_clear;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [ACC_W-1:0] o_acc;
  logic [CNT_W-1:0] o_count;
  logic             o_ovf;
  logic             o_err;

  modport master (
    output i_Numerical_Precision, i_product, i_valid, i_last, i_clear, i_out_ready,
    input  o_in_ready, o_out_valid, o_acc, o_count, o_ovf, o_err
  );

  modport slave (
    input  i_Numerical_Precision, i_product, i_valid, i_last, i_clear, i_out_ready,
    output o_in_ready, o_out_valid, o_acc, o_count, o_ovf, o_err
  );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates one group of 48-bit multiplier products into a wide sum with beat count and flags.
// Define ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
//
//  state | meaning
//  IDLE  | waiting for the first beat of a group
//  ACCUM | group open, adding beats until i_last
//  HOLD  | result presented, waiting for i_out_ready
module product_accumulator #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tag_q, tag_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             in_ready_q;

  logic             accept;
  logic [1:0]       tag_eff;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum;
  logic             ovf_new;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      in_ready_q <= (state_d != HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    accept  = bus.i_valid && in_ready_q;
    // The first beat of a group masks with its own tag; later beats use the latched one.
    tag_eff = (state_q == IDLE) ? bus.i_Numerical_Precision : tag_q;
    operand = (tag_eff == 2'b11) ? ACC_W'(bus.i_product) : ACC_W'(bus.i_product[23:0]);
    sum     = {1'b0, acc_q} + {1'b0, operand};
    ovf_new = ovf_q | sum[ACC_W];

    unique case (state_q)
      IDLE: begin
        if (bus.i_clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b0;
        end else if (accept) begin
          tag_d   = bus.i_Numerical_Precision;
          acc_d   = operand;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = bus.i_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.i_clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
`ifdef ACC_SAT_EN
          acc_d = ovf_new ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_new;
          err_d = err_q | (bus.i_Numerical_Precision != tag_q);
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.i_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_out_valid = (state_q == HOLD);
  assign bus.o_acc       = acc_q;
  assign bus.o_count     = cnt_q;
  assign bus.o_ovf       = ovf_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 64-bit/8-bit instance and a 48-bit/3-bit instance checked
// against a whole-group arithmetic model (total sum, then wrap or saturate at the end).
module tb_product_accumulator;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  product_accumulator_if #(.ACC_W(64), .CNT_W(8)) b64 ();
  product_accumulator_if #(.ACC_W(48), .CNT_W(3)) b48 ();

  product_accumulator #(.ACC_W(64), .CNT_W(8)) u64 (.i_clk(i_clk), .i_rst(i_rst), .bus(b64));
  product_accumulator #(.ACC_W(48), .CNT_W(3)) u48 (.i_clk(i_clk), .i_rst(i_rst), .bus(b48));

  int n_total = 0;
  int n_pass  = 0;

  logic [1:0]  q_tag[$];
  logic [47:0] q_prod[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic rdy(input int sel);
    return sel != 0 ? b48.o_in_ready : b64.o_in_ready;
  endfunction
  function automatic logic ovalid(input int sel);
    return sel != 0 ? b48.o_out_valid : b64.o_out_valid;
  endfunction
  function automatic logic [127:0] oacc(input int sel);
    return sel != 0 ? 128'(b48.o_acc) : 128'(b64.o_acc);
  endfunction
  function automatic logic [127:0] ocnt(input int sel);
    return sel != 0 ? 128'(b48.o_count) : 128'(b64.o_count);
  endfunction
  function automatic logic [127:0] oovf(input int sel);
    return sel != 0 ? 128'(b48.o_ovf) : 128'(b64.o_ovf);
  endfunction
  function automatic logic [127:0] oerr(input int sel);
    return sel != 0 ? 128'(b48.o_err) : 128'(b64.o_err);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] t, input logic [47:0] p,
                       input logic l, input logic c);
    if (sel != 0) begin
      b48.i_valid = v; b48.i_Numerical_Precision = t; b48.i_product = p;
      b48.i_last = l; b48.i_clear = c;
    end else begin
      b64.i_valid = v; b64.i_Numerical_Precision = t; b64.i_product = p;
      b64.i_last = l; b64.i_clear = c;
    end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel != 0) b48.i_out_ready = r;
    else b64.i_out_ready = r;
  endtask

  task automatic send_beat(input int sel, input logic [1:0] t, input logic [47:0] p, input logic l);
    int w = 0;
    @(negedge i_clk);
    while (!rdy(sel) && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 128'(rdy(sel)), 128'd1);
    drive(sel, 1'b1, t, p, l, 1'b0);
    @(posedge i_clk);
    #1 drive(sel, 1'b0, 2'b00, 48'd0, 1'b0, 1'b0);
  endtask

  // Whole-group reference: exact sum of masked operands, reduced at the end.
  task automatic model(input int acc_w, input int cnt_w, output logic [127:0] e_acc,
                       output logic [127:0] e_cnt, output logic [127:0] e_ovf,
                       output logic [127:0] e_err);
    logic [127:0] s, lim, cmax;
    logic [1:0]   t0;
    s = '0;
    e_err = '0;
    t0 = q_tag[0];
    for (int i = 0; i < q_prod.size(); i++) begin
      s += (t0 == 2'b11) ? 128'(q_prod[i]) : 128'(q_prod[i] & 48'hFFFFFF);
      if (q_tag[i] != t0) e_err = 128'd1;
    end
    lim   = 128'd1 << acc_w;
    e_ovf = (s >= lim) ? 128'd1 : 128'd0;
`ifdef ACC_SAT_EN
    e_acc = (s >= lim) ? lim - 1 : s;
`else
    e_acc = s & (lim - 1);
`endif
    cmax  = (128'd1 << cnt_w) - 1;
    e_cnt = (128'(q_prod.size()) > cmax) ? cmax : 128'(q_prod.size());
  endtask

  task automatic run_group(input int sel, input int hold, input string name);
    logic [127:0] e_acc, e_cnt, e_ovf, e_err;
    int w = 0;
    for (int i = 0; i < q_prod.size(); i++)
      send_beat(sel, q_tag[i], q_prod[i], (i == q_prod.size() - 1));
    while (!ovalid(sel) && w < 20) begin
      @(posedge i_clk);
      #1 w++;
    end
    if (sel != 0) model(48, 3, e_acc, e_cnt, e_ovf, e_err);
    else model(64, 8, e_acc, e_cnt, e_ovf, e_err);
    chk({name, "_valid"}, 128'(ovalid(sel)), 128'd1);
    chk({name, "_acc"}, oacc(sel), e_acc);
    chk({name, "_count"}, ocnt(sel), e_cnt);
    chk({name, "_ovf"}, oovf(sel), e_ovf);
    chk({name, "_err"}, oerr(sel), e_err);
    // While held, offer a beat and a clear; neither may disturb the result.
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clk);
      chk({name, "_hold_acc"}, oacc(sel), e_acc);
      chk({name, "_hold_valid"}, 128'(ovalid(sel)), 128'd1);
      chk({name, "_hold_inrdy"}, 128'(rdy(sel)), 128'd0);
      drive(sel, 1'b1, 2'b11, 48'h123, 1'b1, (k == 0));
    end
    @(negedge i_clk);
    drive(sel, 1'b0, 2'b00, 48'd0, 1'b0, 1'b0);
    set_ordy(sel, 1'b1);
    @(posedge i_clk);
    #1 set_ordy(sel, 1'b0);
    chk({name, "_release_valid"}, 128'(ovalid(sel)), 128'd0);
    chk({name, "_release_inrdy"}, 128'(rdy(sel)), 128'd1);
    q_tag.delete();
    q_prod.delete();
  endtask

  task automatic push(input logic [1:0] t, input logic [47:0] p);
    q_tag.push_back(t);
    q_prod.push_back(p);
  endtask

  initial begin
    drive(0, 1'b0, 2'b00, 48'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 2'b00, 48'd0, 1'b0, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    #12;
    chk("rst_valid", 128'(b64.o_out_valid), 128'd0);
    chk("rst_acc", 128'(b64.o_acc), 128'd0);
    chk("rst_inrdy", 128'(b64.o_in_ready), 128'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1 chk("post_rst_inrdy", 128'(b64.o_in_ready), 128'd1);

    repeat (3) push(2'b11, 48'hFFFFFE000001);
    run_group(0, 0, "t1");
    chk("t1_lit", 128'(b64.o_acc), 128'h2FFFFFA000003);

    repeat (2) push(2'b01, 48'hABCDEFFFE001);
    run_group(0, 1, "t2");

    push(2'b11, 48'hFFFFFFFFFFFF);
    push(2'b11, 48'h000000000001);
    run_group(1, 0, "t3");

    push(2'b10, 48'h0000_1234_5678);
    push(2'b10, 48'h0000_0000_0009);
    run_group(0, 5, "t4");

    push(2'b11, 48'd5);
    push(2'b01, 48'd7);
    run_group(0, 0, "t5");
    send_beat(0, 2'b11, 48'd1, 1'b0);
    chk("t5_next_err", 128'(b64.o_err), 128'd0);
    send_beat(0, 2'b11, 48'd2, 1'b1);
    chk("t5_next_acc", 128'(b64.o_acc), 128'd3);
    @(negedge i_clk);
    set_ordy(0, 1'b1);
    @(posedge i_clk);
    #1 set_ordy(0, 1'b0);

    // Asynchronous reset mid-group.
    send_beat(0, 2'b11, 48'd100, 1'b0);
    send_beat(0, 2'b11, 48'd200, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    chk("t6_rst_acc", 128'(b64.o_acc), 128'd0);
    chk("t6_rst_count", 128'(b64.o_count), 128'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    push(2'b11, 48'd5);
    run_group(0, 0, "t6r");

    // Clear mid-group overrides a simultaneous last beat.
    send_beat(0, 2'b11, 48'd100, 1'b0);
    send_beat(0, 2'b11, 48'd200, 1'b0);
    @(negedge i_clk);
    drive(0, 1'b1, 2'b11, 48'd99, 1'b1, 1'b1);
    @(posedge i_clk);
    #1 drive(0, 1'b0, 2'b00, 48'd0, 1'b0, 1'b0);
    chk("t6c_valid", 128'(b64.o_out_valid), 128'd0);
    chk("t6c_acc", 128'(b64.o_acc), 128'd0);
    chk("t6c_count", 128'(b64.o_count), 128'd0);
    push(2'b11, 48'd5);
    run_group(0, 0, "t6c");

    // Count saturation on the 3-bit counter.
    repeat (9) push(2'b01, 48'd3);
    run_group(1, 0, "sat_cnt");

    for (int g = 0; g < 24; g++) begin
      int sel, n;
      logic [1:0] bt;
      sel = g % 2;
      n = $urandom_range(1, (sel != 0) ? 10 : 6);
      bt = 2'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        logic [47:0] p;
        p = {16'($urandom), $urandom};
        push(($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : bt, p);
      end
      run_group(sel, $urandom_range(0, 2), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
